// File: rtl/count_uart_tx_if.sv
// Bundles the capture inputs and UART/status outputs of count_uart_tx.
// The slave modport is the DUT side; the master modport is the driver/monitor side.
interface count_uart_tx_if;
  logic       ena;
  logic [3:0] count_in;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_level;

  modport slave (
    input  ena,
    input  count_in,
    output tx,
    output busy,
    output overflow,
    output fifo_level
  );

  modport master (
    output ena,
    output count_in,
    input  tx,
    input  busy,
    input  overflow,
    input  fifo_level
  );
endinterface

// File: rtl/count_uart_tx.sv
// Streams changes of a 4-bit count as ASCII hex characters over an 8N1 UART,
// buffered by a 4-entry FIFO with a sticky overflow flag.
//
// state | meaning
// IDLE  | line high, waiting for a queued character
// START | start bit (low)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (high); may chain straight into the next START
module count_uart_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  count_uart_tx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_last_count;
  logic [7:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_level;
  logic       r_overflow;
  logic [7:0] r_shift;
  logic [7:0] r_bit_cnt;
  logic [2:0] r_bit_idx;

  logic       w_capture;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic       w_bit_done;
  logic [7:0] w_char;

  assign w_capture    = bus.ena && (bus.count_in != r_last_count);
  assign w_fifo_full  = (r_level == 3'd4);
  assign w_fifo_empty = (r_level == 3'd0);
  assign w_bit_done   = (r_bit_cnt == 8'd0);
  // A full FIFO still accepts a push when the transmitter pops on the same edge.
  assign w_push       = w_capture && (!w_fifo_full || w_pop);
  assign w_drop       = w_capture && w_fifo_full && !w_pop;

  always_comb begin
    w_char = 8'h00;
    if (bus.count_in < 4'd10) w_char = {4'h3, bus.count_in};
    else                      w_char = 8'h37 + {4'h0, bus.count_in};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_done) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_bit_done && (r_bit_idx == 3'd7)) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_bit_done) begin
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_count <= 4'h0;
      r_wr_ptr     <= 2'd0;
      r_rd_ptr     <= 2'd0;
      r_level      <= 3'd0;
      r_overflow   <= 1'b0;
      r_shift      <= 8'h00;
      r_bit_cnt    <= RELOAD;
      r_bit_idx    <= 3'd0;
    end else begin
      r_state <= w_state_nxt;

      if (w_capture) r_last_count <= bus.count_in;
      if (w_drop)    r_overflow   <= 1'b1;

      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 3'd1;
        2'b01:   r_level <= r_level - 3'd1;
        default: r_level <= r_level;
      endcase

      // Bit timer reloads at every bit boundary so frames never drift.
      if (w_pop || ((r_state != IDLE) && w_bit_done)) r_bit_cnt <= RELOAD;
      else if (r_state != IDLE)                        r_bit_cnt <= r_bit_cnt - 8'd1;

      if (w_pop) begin
        r_shift   <= r_mem[r_rd_ptr];
        r_bit_idx <= 3'd0;
      end else if ((r_state == DATA) && w_bit_done) begin
        r_shift   <= {1'b0, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wr_ptr] <= w_char;
  end

  assign bus.tx         = (r_state == START) ? 1'b0 :
                          (r_state == DATA)  ? r_shift[0] : 1'b1;
  assign bus.busy       = (r_state != IDLE);
  assign bus.overflow   = r_overflow;
  assign bus.fifo_level = r_level;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx with CLKS_PER_BIT=4; expected frames are
// built from hand-chosen ASCII characters.
module tb_count_uart_tx;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  count_uart_tx_if bus ();

  count_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] exp_frame(input logic [7:0] ch);
    logic [9:0]  f;
    logic [39:0] r;
    f = {1'b1, ch, 1'b0};
    for (int i = 0; i < 40; i++) r[i] = f[i / 4];
    return r;
  endfunction

  // Samples 40 cycles starting at the current (first start-bit) cycle.
  task automatic grab_frame(output logic [39:0] obs, output int busy_hi);
    busy_hi = 0;
    for (int i = 0; i < 40; i++) begin
      obs[i] = bus.tx;
      if (bus.busy) busy_hi++;
      step();
    end
  endtask

  task automatic single_frame(input logic [3:0] val, input logic [7:0] ch, input string tag);
    logic [39:0] obs;
    int          bh;
    bus.count_in = val;
    step();
    chk({tag, "_level_after_capture"}, 40'(bus.fifo_level), 40'd1);
    chk({tag, "_tx_idle_on_capture"}, 40'(bus.tx), 40'd1);
    step();
    grab_frame(obs, bh);
    chk({tag, "_frame"}, obs, exp_frame(ch));
    chk({tag, "_busy_cycles"}, 40'(bh), 40'd40);
    chk({tag, "_busy_after"}, 40'(bus.busy), 40'd0);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.ena      = 1'b1;
    bus.count_in = 4'h0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [39:0] f1;
    logic [39:0] obs;
    logic [2:0]  lv [5];
    int          bh;
    int          total;

    checks = 0;
    errors = 0;
    lv = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

    // reset state
    rst_n        = 1'b0;
    bus.ena      = 1'b0;
    bus.count_in = 4'h7;
    step();
    chk("rst_tx", 40'(bus.tx), 40'd1);
    chk("rst_busy", 40'(bus.busy), 40'd0);
    chk("rst_overflow", 40'(bus.overflow), 40'd0);
    chk("rst_level", 40'(bus.fifo_level), 40'd0);
    do_reset();

    // count_in equal to the reset value of last_count yields no frame
    for (int i = 0; i < 4; i++) step();
    chk("zero_no_frame_busy", 40'(bus.busy), 40'd0);
    chk("zero_no_frame_level", 40'(bus.fifo_level), 40'd0);

    single_frame(4'h1, 8'h31, "f31");
    single_frame(4'hA, 8'h41, "f41");
    single_frame(4'hF, 8'h46, "f46");

    // ena low: toggling count_in is ignored
    bus.ena = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus.count_in = 4'(i);
      step();
      chk("ena0_level", 40'(bus.fifo_level), 40'd0);
      chk("ena0_busy", 40'(bus.busy), 40'd0);
    end
    bus.count_in = 4'hF;
    bus.ena      = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("same_value_busy", 40'(bus.busy), 40'd0);
    chk("same_value_level", 40'(bus.fifo_level), 40'd0);

    // six changes on consecutive edges: one popped, four queued, one dropped
    bus.count_in = 4'h1;
    step();
    chk("burst_level0", 40'(bus.fifo_level), 40'd1);
    bus.count_in = 4'h2;
    step();
    total = 0;
    for (int i = 0; i < 5; i++) begin
      f1[i] = bus.tx;
      if (bus.busy) total++;
      chk("burst_level", 40'(bus.fifo_level), 40'(lv[i]));
      chk("burst_overflow", 40'(bus.overflow), (i == 4) ? 40'd1 : 40'd0);
      if (i < 4) bus.count_in = 4'(3 + i);
      step();
    end
    for (int i = 5; i < 40; i++) begin
      f1[i] = bus.tx;
      if (bus.busy) total++;
      step();
    end
    chk("burst_frame1", f1, exp_frame(8'h31));
    chk("burst_level_after_f1", 40'(bus.fifo_level), 40'd3);
    for (int k = 2; k <= 5; k++) begin
      grab_frame(obs, bh);
      total += bh;
      chk("burst_frame", obs, exp_frame(8'h30 + 8'(k)));
    end
    chk("burst_busy_total", 40'(total), 40'd200);
    chk("burst_idle_after", 40'(bus.busy), 40'd0);
    chk("burst_level_end", 40'(bus.fifo_level), 40'd0);
    chk("burst_overflow_sticky", 40'(bus.overflow), 40'd1);

    // full FIFO, capture on the same edge as the end-of-STOP pop
    do_reset();
    chk("rst2_overflow", 40'(bus.overflow), 40'd0);
    for (int i = 1; i <= 5; i++) begin
      bus.count_in = 4'(i);
      step();
    end
    chk("full_level", 40'(bus.fifo_level), 40'd4);
    for (int i = 0; i < 36; i++) step();
    chk("full_level_pre_pop", 40'(bus.fifo_level), 40'd4);
    chk("full_stop_bit", 40'(bus.tx), 40'd1);
    bus.count_in = 4'h6;
    step();
    chk("pushpop_level", 40'(bus.fifo_level), 40'd4);
    chk("pushpop_overflow", 40'(bus.overflow), 40'd0);
    chk("pushpop_next_start", 40'(bus.tx), 40'd0);

    // reset in the middle of a frame with two characters queued
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      bus.count_in = 4'(i);
      step();
    end
    for (int i = 0; i < 13; i++) step();
    chk("mid_level", 40'(bus.fifo_level), 40'd2);
    chk("mid_busy", 40'(bus.busy), 40'd1);
    rst_n = 1'b0;
    bus.count_in = 4'h9;
    step();
    chk("abort_tx", 40'(bus.tx), 40'd1);
    chk("abort_busy", 40'(bus.busy), 40'd0);
    chk("abort_level", 40'(bus.fifo_level), 40'd0);
    chk("abort_overflow", 40'(bus.overflow), 40'd0);
    bus.count_in = 4'h0;
    rst_n = 1'b1;
    bh = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.busy || !bus.tx) bh++;
      step();
    end
    chk("abort_no_frames", 40'(bh), 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_uart_tx.md
COUNT_UART_TX -- requirements
Module: count_uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 4, clock cycles per UART bit; legal range 2..255.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: ena  input  1  capture enable; gates sampling of count_in only.
REQ-005 SHALL have port: count_in  input  4  4-bit count value from the upstream counter stage.
REQ-006 SHALL have port: tx  output  1  UART serial line, 8N1, idle high.
REQ-007 SHALL have port: busy  output  1  high while a frame is in progress.
REQ-008 SHALL have port: overflow  output  1  sticky flag: a captured value was dropped.
REQ-009 SHALL have port: fifo_level  output  3  number of queued characters, 0..4.

Function
REQ-010 SHALL hold register last_count (4 bits); at each edge with ena=1 and count_in != last_count, a change is captured and last_count <= count_in.
REQ-011 SHALL ignore count_in entirely when ena=0; last_count holds.
REQ-012 SHALL encode each captured value as an ASCII hex character: 0x0-0x9 -> 0x30-0x39, 0xA-0xF -> 0x41-0x46 (uppercase).
REQ-013 SHALL write the encoded character into a 4-entry FIFO on the capture edge; fifo_level reflects the write after that edge.
REQ-014 SHALL drop the new character and set overflow=1 when a capture occurs with FIFO full and no pop on that edge; overflow clears only on reset.
REQ-015 SHALL accept a push when the FIFO is full and a pop occurs on the same edge; level stays 4, no overflow.
REQ-016 SHALL not bypass: a pop requires the FIFO to be non-empty before the edge; a capture into an empty FIFO is transmitted no earlier than the next edge.
REQ-017 SHALL implement the TX FSM with states IDLE, START, DATA, STOP.
REQ-018 SHALL, in IDLE with the FIFO non-empty at an edge, pop the head into a shift register and enter START.
REQ-019 SHALL drive tx low for CLKS_PER_BIT cycles in START.
REQ-020 SHALL transmit 8 data bits LSB first in DATA, each held CLKS_PER_BIT cycles.
REQ-021 SHALL drive tx high for CLKS_PER_BIT cycles in STOP.
REQ-022 SHALL, at the end of STOP, pop and go directly to START if the FIFO is non-empty (back-to-back frames, no idle gap); otherwise go to IDLE.
REQ-023 SHALL make a frame exactly 10*CLKS_PER_BIT cycles long; tx falls on the edge after the capture edge when idle (1-cycle latency).
REQ-024 SHALL drive tx=1 in IDLE and busy=1 in every state except IDLE.
REQ-025 SHALL keep transmitting and draining the FIFO irrespective of ena.
REQ-026 SHALL implement bit timing as a down-counter reloaded per bit and a 3-bit data bit index; there is no wrap or skew between frames.

Reset
REQ-027 SHALL, on an edge with rst_n=0, force tx=1, busy=0, overflow=0, fifo_level=0, last_count=0, FSM=IDLE, and FIFO pointers=0.
REQ-028 SHALL make reset dominate capture and pop on the same edge.
REQ-029 SHALL make reset mid-frame abort the frame immediately (tx=1 after that edge) and discard all queued characters.
REQ-030 SHALL produce no frame when count_in stays 0 after reset (equals last_count reset value).

Verification (CLKS_PER_BIT=4)
REQ-031 SHALL test: reset, ena=1, count_in 0->1 -> tx low from next edge; bits 0,1,0,0,0,1,1,0,0,1 (start, 0x31 LSB first, stop), each 4 cycles; busy high 40 cycles.
REQ-032 SHALL test: count_in 0->0xA -> frame carries 0x41; count_in 0xA->0xF -> next frame 0x46.
REQ-033 SHALL test: six distinct changes on consecutive edges from idle -> first popped at once, next four fill FIFO (fifo_level=4), sixth dropped, overflow=1; exactly five back-to-back frames, 200 cycles busy.
REQ-034 SHALL test: ena=0 while count_in toggles 1..5 -> no frames, fifo_level=0; ena=1 with count_in equal to last_count -> no frame.
REQ-035 SHALL test: rst_n low at cycle 15 of a frame with fifo_level=2 -> next edge tx=1, busy=0, fifo_level=0, overflow=0; no further frames.
REQ-036 SHALL test: FIFO full, capture coinciding with end-of-STOP pop -> fifo_level stays 4, overflow stays 0.
